// File: rtl/mult_pkg.sv
// Shared widths and output-slot state for the time-shared 5x5 multiplier.
package mult_pkg;

    localparam int MULT_IN_W  = 5;
    localparam int MULT_OUT_W = 10;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/mult.sv
// Combinational unsigned multiplier; the full-width product is kept, never truncated.
module mult
    import mult_pkg::*;
(
    input  logic [MULT_IN_W-1:0]  i_a,
    input  logic [MULT_IN_W-1:0]  i_b,
    output logic [MULT_OUT_W-1:0] o_p
);

    assign o_p = MULT_OUT_W'(i_a) * MULT_OUT_W'(i_b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx
);

    logic            w_found;
    int              w_sum;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        // NOTE: every variable gets a default before the search so no path leaves one unassigned, which would infer a latch.
        w_found = 1'b0;
        w_sum   = 0;
        w_cand  = '0;
        o_idx   = '0;
        o_grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum  = (int'(i_ptr) + k) % N_REQ;
            w_cand = ID_W'(w_sum);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (i_en && w_found) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier among N_REQ lanes: round-robin grant, product registered
// into a single output slot tagged with the winning lane index.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [MULT_IN_W*N_REQ-1:0] req_a,
    input  logic [MULT_IN_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       resp_valid,
    output logic [ID_W-1:0]            resp_id,
    output logic [MULT_OUT_W-1:0]      resp_data,
    input  logic                       resp_ready
);

    slot_state_e           r_state;
    slot_state_e           w_state_nxt;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_id;
    logic [MULT_OUT_W-1:0] r_data;

    logic                  w_can_accept;
    logic                  w_accept;
    logic [N_REQ-1:0]      w_grant;
    logic [ID_W-1:0]       w_idx;
    logic [MULT_IN_W-1:0]  w_a;
    logic [MULT_IN_W-1:0]  w_b;
    logic [MULT_OUT_W-1:0] w_prod;

    // Reset also masks grants so req_ready reads zero while rst is held.
    assign w_can_accept = !rst && ((r_state == SLOT_EMPTY) || resp_ready);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_can_accept),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_accept  = |w_grant;
    assign req_ready = w_grant;

    assign w_a = req_a[w_idx*MULT_IN_W +: MULT_IN_W];
    assign w_b = req_b[w_idx*MULT_IN_W +: MULT_IN_W];

    mult u_mult (
        .i_a (w_a),
        .i_b (w_b),
        .o_p (w_prod)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_accept)                 w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (resp_ready && !w_accept)  w_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= w_prod;
                r_id   <= w_idx;
                r_ptr  <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign resp_valid = (r_state == SLOT_FULL);
    assign resp_id    = r_id;
    assign resp_data  = r_data;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one 5×5 unsigned multiplier (`mult`, 10-bit product) among `N_REQ` neuron lanes using round-robin arbitration. Each lane presents an operand pair with a valid/ready handshake. The winning pair is multiplied and the product is registered into a single output slot, tagged with the requester index. The block sits between the per-neuron weight/activation fetch logic and the accumulators, so the design needs one `mult` instance instead of one per neuron.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester index; must equal ceil(log2(N_REQ)).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  N_REQ  bit i set: requester i holds an operand pair.
- `req_a`  in  5*N_REQ  operand a of requester i in bits [5i+4:5i].
- `req_b`  in  5*N_REQ  operand b of requester i in bits [5i+4:5i].
- `req_ready`  out  N_REQ  one-hot (or zero) grant; the pair is accepted when req_valid[i] && req_ready[i].
- `resp_valid`  out  1  output slot is full.
- `resp_id`  out  ID_W  index of the requester that owns the product.
- `resp_data`  out  10  unsigned product a*b.
- `resp_ready`  in  1  the consumer takes the product this cycle.

## Operation
- The output slot state machine has two states.
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1; resp_id and resp_data are held stable.
- Transitions:
  - EMPTY → FULL when a grant is issued.
  - FULL → EMPTY when resp_ready=1 and no new grant is issued.
  - FULL → FULL when resp_ready=1 with a new grant (back-to-back).
  - FULL stays FULL, with the slot unchanged, while resp_ready=0.
- A grant is allowed when `can_accept = (state==EMPTY) || resp_ready`.
- Arbitration is round-robin from pointer `rr_ptr`. The winner is the first requester with req_valid set, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
- req_ready is combinational: one-hot at the winner when can_accept=1, otherwise all zero. It depends on req_valid, rr_ptr, state and resp_ready only, never on req_a or req_b.
- On an accepted pair: the slot loads `mult(req_a[w], req_b[w])` and resp_id=w, and rr_ptr becomes (w+1) mod N_REQ.
- Without a grant, rr_ptr holds.
- The product is the full 10-bit unsigned result with no truncation or saturation. Any fixed-point interpretation belongs to the consumer.
- Fairness: a requester holding req_valid continuously is granted within N_REQ accepted transactions.
- Requesters must hold req_valid, req_a and req_b stable until they are accepted. The block does not check this.

## Timing
- Reset values: state=EMPTY, resp_valid=0, resp_id=0, resp_data=0, rr_ptr=0, req_ready=0.
- Reset during operation drops any held product immediately, with no response issued.
- Latency: a pair accepted at edge k appears with resp_valid=1 after edge k, i.e. in cycle k+1.
- Throughput: one product per cycle while resp_ready stays high.
- Backpressure: with resp_ready=0 and state FULL, req_ready is all zero and the slot holds.
- When resp_ready=1 and a requester is valid in the same cycle, the drain and the new load happen on the same edge, with no bubble.
- resp_ready while EMPTY is ignored.
- With all req_valid=0, nothing is granted, rr_ptr holds, and the slot drains normally.
- The `mult` instance is combinational and sits on the path from the operand mux to the slot register. There is no internal pipelining.

## Structure
- Package `mult_pkg`:
  - `MULT_IN_W=5`, `MULT_OUT_W=10`.
  - Output slot state enum `{SLOT_EMPTY, SLOT_FULL}`.
- Sub-module `rr_arbiter`, parameterised by N_REQ:
  - Inputs: req vector, ptr, enable.
  - Output: one-hot grant and the encoded winner index.
  - Purely combinational.
- The top level contains:
  - the operand muxes;
  - one `mult` instance;
  - the slot registers;
  - the rr_ptr register.

## Test plan
- Reset and idle: assert rst mid-stream with the slot FULL → resp_valid=0, req_ready=0 and rr_ptr=0 immediately; after release with no requests, outputs stay 0.
- Single requester:
  - Lane 0 with a=5'b11111, b=5'b10101 → one cycle later resp_valid=1, resp_id=0, resp_data=651 (10'b1010001011).
  - Repeat with a=26, b=8 → resp_data=208.
- All four lanes valid continuously, resp_ready=1:
  - Grants go 0,1,2,3,0,… on consecutive cycles.
  - Products for pairs (31,21), (26,8), (6,12) and (15,15) are 651, 208, 72 and 225, with matching resp_id.
- Backpressure:
  - Hold resp_ready=0 for 3 cycles with the slot FULL → req_ready=0 and resp_data is stable.
  - Then raise resp_ready with lane 2 valid → drain and load on the same edge, and resp_id=2 next cycle.
- Fairness and pointer:
  - Lanes 1 and 3 valid, rr_ptr=2 → lane 3 is granted first, then lane 1, then lane 3.
  - A lane that drops valid is skipped with no idle cycle.
- Boundary operands:
  - a=0, b=31 → resp_data=0.
  - a=31, b=31 → resp_data=961, with no overflow.
  - A random self-checking sweep of all 1024 operand pairs through lane N_REQ-1 matches a*b.
